// File: rtl/sin_lut.sv
// -----------------------------------------------------------------------------
// sin_lut -- synchronous quarter-wave sine lookup ROM
//
// Maps an unsigned first-quadrant phase index to an unsigned sine magnitude.
// Entry k holds round(255 * sin((pi/2) * k / 255)), rounded half up and
// saturated to 0..255. The result is a non-decreasing table from 0 to 255.
// Quadrant folding and sign handling belong to the surrounding datapath.
//
// Parameters:
//   DATA_WIDTH  output sample width (only 8 is supported)
//   ADDR_WIDTH  phase index width   (only 8 is supported, 256 entries)
//
// Ports:
//   clk    in   1           system clock, rising-edge active
//   rst    in   1           synchronous reset, active-high; clears d_out
//   rd     in   1           read enable; loads entry[addr] into d_out
//   addr   in   ADDR_WIDTH  phase index, angle (pi/2)*addr/255
//   d_in   in   DATA_WIDTH  unused; present so the port list matches the
//                           RAM blocks this ROM is swapped with
//   d_out  out  DATA_WIDTH  registered sine sample, 1 clock read latency
// -----------------------------------------------------------------------------
module sin_lut #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out
);

    logic [DATA_WIDTH-1:0] r_d_out;
    logic                  w_unused_d_in;

    // The table is read-only; d_in is only reduced here to keep it visibly
    // consumed without it reaching any logic.
    assign w_unused_d_in = ^d_in;

    // Fixed table. Entry 85 is exactly 127.5 (sin 30 deg) and rounds up to 128.
    function automatic logic [DATA_WIDTH-1:0] sin_entry(input logic [ADDR_WIDTH-1:0] k);
        logic [DATA_WIDTH-1:0] t;
        t = '0;
        case (k)
            8'd0:   t = 8'd0;   8'd1:   t = 8'd2;   8'd2:   t = 8'd3;   8'd3:   t = 8'd5;
            8'd4:   t = 8'd6;   8'd5:   t = 8'd8;   8'd6:   t = 8'd9;   8'd7:   t = 8'd11;
            8'd8:   t = 8'd13;  8'd9:   t = 8'd14;  8'd10:  t = 8'd16;  8'd11:  t = 8'd17;
            8'd12:  t = 8'd19;  8'd13:  t = 8'd20;  8'd14:  t = 8'd22;  8'd15:  t = 8'd24;
            8'd16:  t = 8'd25;  8'd17:  t = 8'd27;  8'd18:  t = 8'd28;  8'd19:  t = 8'd30;
            8'd20:  t = 8'd31;  8'd21:  t = 8'd33;  8'd22:  t = 8'd34;  8'd23:  t = 8'd36;
            8'd24:  t = 8'd38;  8'd25:  t = 8'd39;  8'd26:  t = 8'd41;  8'd27:  t = 8'd42;
            8'd28:  t = 8'd44;  8'd29:  t = 8'd45;  8'd30:  t = 8'd47;  8'd31:  t = 8'd48;
            8'd32:  t = 8'd50;  8'd33:  t = 8'd51;  8'd34:  t = 8'd53;  8'd35:  t = 8'd55;
            8'd36:  t = 8'd56;  8'd37:  t = 8'd58;  8'd38:  t = 8'd59;  8'd39:  t = 8'd61;
            8'd40:  t = 8'd62;  8'd41:  t = 8'd64;  8'd42:  t = 8'd65;  8'd43:  t = 8'd67;
            8'd44:  t = 8'd68;  8'd45:  t = 8'd70;  8'd46:  t = 8'd71;  8'd47:  t = 8'd73;
            8'd48:  t = 8'd74;  8'd49:  t = 8'd76;  8'd50:  t = 8'd77;  8'd51:  t = 8'd79;
            8'd52:  t = 8'd80;  8'd53:  t = 8'd82;  8'd54:  t = 8'd83;  8'd55:  t = 8'd85;
            8'd56:  t = 8'd86;  8'd57:  t = 8'd88;  8'd58:  t = 8'd89;  8'd59:  t = 8'd91;
            8'd60:  t = 8'd92;  8'd61:  t = 8'd94;  8'd62:  t = 8'd95;  8'd63:  t = 8'd96;
            8'd64:  t = 8'd98;  8'd65:  t = 8'd99;  8'd66:  t = 8'd101; 8'd67:  t = 8'd102;
            8'd68:  t = 8'd104; 8'd69:  t = 8'd105; 8'd70:  t = 8'd107; 8'd71:  t = 8'd108;
            8'd72:  t = 8'd109; 8'd73:  t = 8'd111; 8'd74:  t = 8'd112; 8'd75:  t = 8'd114;
            8'd76:  t = 8'd115; 8'd77:  t = 8'd116; 8'd78:  t = 8'd118; 8'd79:  t = 8'd119;
            8'd80:  t = 8'd121; 8'd81:  t = 8'd122; 8'd82:  t = 8'd123; 8'd83:  t = 8'd125;
            8'd84:  t = 8'd126; 8'd85:  t = 8'd128; 8'd86:  t = 8'd129; 8'd87:  t = 8'd130;
            8'd88:  t = 8'd132; 8'd89:  t = 8'd133; 8'd90:  t = 8'd134; 8'd91:  t = 8'd136;
            8'd92:  t = 8'd137; 8'd93:  t = 8'd138; 8'd94:  t = 8'd140; 8'd95:  t = 8'd141;
            8'd96:  t = 8'd142; 8'd97:  t = 8'd143; 8'd98:  t = 8'd145; 8'd99:  t = 8'd146;
            8'd100: t = 8'd147; 8'd101: t = 8'd149; 8'd102: t = 8'd150; 8'd103: t = 8'd151;
            8'd104: t = 8'd152; 8'd105: t = 8'd154; 8'd106: t = 8'd155; 8'd107: t = 8'd156;
            8'd108: t = 8'd157; 8'd109: t = 8'd159; 8'd110: t = 8'd160; 8'd111: t = 8'd161;
            8'd112: t = 8'd162; 8'd113: t = 8'd164; 8'd114: t = 8'd165; 8'd115: t = 8'd166;
            8'd116: t = 8'd167; 8'd117: t = 8'd168; 8'd118: t = 8'd169; 8'd119: t = 8'd171;
            8'd120: t = 8'd172; 8'd121: t = 8'd173; 8'd122: t = 8'd174; 8'd123: t = 8'd175;
            8'd124: t = 8'd176; 8'd125: t = 8'd178; 8'd126: t = 8'd179; 8'd127: t = 8'd180;
            8'd128: t = 8'd181; 8'd129: t = 8'd182; 8'd130: t = 8'd183; 8'd131: t = 8'd184;
            8'd132: t = 8'd185; 8'd133: t = 8'd186; 8'd134: t = 8'd187; 8'd135: t = 8'd188;
            8'd136: t = 8'd190; 8'd137: t = 8'd191; 8'd138: t = 8'd192; 8'd139: t = 8'd193;
            8'd140: t = 8'd194; 8'd141: t = 8'd195; 8'd142: t = 8'd196; 8'd143: t = 8'd197;
            8'd144: t = 8'd198; 8'd145: t = 8'd199; 8'd146: t = 8'd200; 8'd147: t = 8'd201;
            8'd148: t = 8'd202; 8'd149: t = 8'd203; 8'd150: t = 8'd203; 8'd151: t = 8'd204;
            8'd152: t = 8'd205; 8'd153: t = 8'd206; 8'd154: t = 8'd207; 8'd155: t = 8'd208;
            8'd156: t = 8'd209; 8'd157: t = 8'd210; 8'd158: t = 8'd211; 8'd159: t = 8'd212;
            8'd160: t = 8'd213; 8'd161: t = 8'd213; 8'd162: t = 8'd214; 8'd163: t = 8'd215;
            8'd164: t = 8'd216; 8'd165: t = 8'd217; 8'd166: t = 8'd218; 8'd167: t = 8'd218;
            8'd168: t = 8'd219; 8'd169: t = 8'd220; 8'd170: t = 8'd221; 8'd171: t = 8'd222;
            8'd172: t = 8'd222; 8'd173: t = 8'd223; 8'd174: t = 8'd224; 8'd175: t = 8'd225;
            8'd176: t = 8'd225; 8'd177: t = 8'd226; 8'd178: t = 8'd227; 8'd179: t = 8'd228;
            8'd180: t = 8'd228; 8'd181: t = 8'd229; 8'd182: t = 8'd230; 8'd183: t = 8'd230;
            8'd184: t = 8'd231; 8'd185: t = 8'd232; 8'd186: t = 8'd232; 8'd187: t = 8'd233;
            8'd188: t = 8'd234; 8'd189: t = 8'd234; 8'd190: t = 8'd235; 8'd191: t = 8'd235;
            8'd192: t = 8'd236; 8'd193: t = 8'd237; 8'd194: t = 8'd237; 8'd195: t = 8'd238;
            8'd196: t = 8'd238; 8'd197: t = 8'd239; 8'd198: t = 8'd239; 8'd199: t = 8'd240;
            8'd200: t = 8'd241; 8'd201: t = 8'd241; 8'd202: t = 8'd242; 8'd203: t = 8'd242;
            8'd204: t = 8'd243; 8'd205: t = 8'd243; 8'd206: t = 8'd243; 8'd207: t = 8'd244;
            8'd208: t = 8'd244; 8'd209: t = 8'd245; 8'd210: t = 8'd245; 8'd211: t = 8'd246;
            8'd212: t = 8'd246; 8'd213: t = 8'd247; 8'd214: t = 8'd247; 8'd215: t = 8'd247;
            8'd216: t = 8'd248; 8'd217: t = 8'd248; 8'd218: t = 8'd248; 8'd219: t = 8'd249;
            8'd220: t = 8'd249; 8'd221: t = 8'd249; 8'd222: t = 8'd250; 8'd223: t = 8'd250;
            8'd224: t = 8'd250; 8'd225: t = 8'd251; 8'd226: t = 8'd251; 8'd227: t = 8'd251;
            8'd228: t = 8'd251; 8'd229: t = 8'd252; 8'd230: t = 8'd252; 8'd231: t = 8'd252;
            8'd232: t = 8'd252; 8'd233: t = 8'd253; 8'd234: t = 8'd253; 8'd235: t = 8'd253;
            8'd236: t = 8'd253; 8'd237: t = 8'd253; 8'd238: t = 8'd254; 8'd239: t = 8'd254;
            8'd240: t = 8'd254; 8'd241: t = 8'd254; 8'd242: t = 8'd254; 8'd243: t = 8'd254;
            8'd244: t = 8'd254; 8'd245: t = 8'd255; 8'd246: t = 8'd255; 8'd247: t = 8'd255;
            8'd248: t = 8'd255; 8'd249: t = 8'd255; 8'd250: t = 8'd255; 8'd251: t = 8'd255;
            8'd252: t = 8'd255; 8'd253: t = 8'd255; 8'd254: t = 8'd255; 8'd255: t = 8'd255;
            default: t = '0;
        endcase
        return t;
    endfunction

    // Output register: reset wins over rd; with rd low the sample is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_out <= '0;
        end else if (rd) begin
            r_d_out <= sin_entry(addr);
        end
    end

    assign d_out = r_d_out;

endmodule

// File: tb/tb_sin_lut.sv
// -----------------------------------------------------------------------------
// tb_sin_lut -- directed checks of the quarter-wave sine ROM against hand
// values and a real-valued round-half-up model.
// -----------------------------------------------------------------------------
module tb_sin_lut;

    localparam real PI = 3.14159265358979323846;

    logic       clk;
    logic       rst;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] d_in;
    logic [7:0] d_out;

    int n_cmp  = 0;
    int n_fail = 0;

    sin_lut #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rd   (rd),
        .addr (addr),
        .d_in (d_in),
        .d_out(d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // round(255*sin(pi*k/510)), half up; the small bias makes the exact
    // 127.5 at k=85 round up regardless of floating-point noise.
    function automatic logic [7:0] model(input int k);
        real x;
        int  r;
        x = 255.0 * $sin(PI * k / 510.0);
        r = $rtoi($floor(x + 0.5 + 1.0e-6));
        if (r > 255) r = 255;
        if (r < 0)   r = 0;
        return r[7:0];
    endfunction

    task automatic check(input string tag, input logic [7:0] exp);
        n_cmp++;
        assert (d_out === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, d_out, exp);
        end
    endtask

    // One active edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] prev;
    logic [7:0] exp_q;
    int         anchor_a [7] = '{0, 1, 64, 128, 192, 254, 255};
    int         anchor_v [7] = '{0, 2, 98, 181, 236, 255, 255};

    initial begin
        rst  = 1'b1;
        rd   = 1'b1;
        addr = 8'd200;
        d_in = 8'd0;

        // Reset held for two edges while a read is requested.
        tick();
        check("reset_edge1", 8'd0);
        tick();
        check("reset_edge2", 8'd0);

        rst  = 1'b0;
        addr = 8'd0;
        tick();
        check("post_reset_addr0", 8'd0);

        // Anchor reads on consecutive edges.
        for (int i = 0; i < 7; i++) begin
            addr = anchor_a[i][7:0];
            tick();
            check($sformatf("anchor_%0d", anchor_a[i]), anchor_v[i][7:0]);
        end

        // Exact half case: 255*sin(30 deg) = 127.5 rounds up.
        addr = 8'd85;
        tick();
        check("half_up_85", 8'd128);

        // Full sweep against the real model, plus monotonicity.
        prev = 8'd0;
        for (int k = 0; k < 256; k++) begin
            addr = k[7:0];
            tick();
            check($sformatf("sweep_%0d", k), model(k));
            n_cmp++;
            assert (d_out >= prev) else begin
                n_fail++;
                $error("FAIL monotonic_%0d: observed %0d below previous %0d", k, d_out, prev);
            end
            prev = d_out;
        end

        // Hold: rd low keeps the last sample while addr moves.
        addr = 8'd128;
        tick();
        check("hold_load_128", 8'd181);
        rd   = 1'b0;
        addr = 8'd10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_cycle_%0d", i), 8'd181);
        end
        rd = 1'b1;
        tick();
        check("hold_release_10", 8'd16);

        // Reset has priority over a read.
        addr = 8'd255;
        tick();
        check("pre_priority_255", 8'd255);
        rst = 1'b1;
        tick();
        check("reset_priority", 8'd0);
        rst = 1'b0;

        // Random reads with d_in toggling every cycle.
        for (int i = 0; i < 24; i++) begin
            addr  = 8'($urandom_range(0, 255));
            d_in  = 8'($urandom_range(0, 255));
            exp_q = model(int'(addr));
            tick();
            check($sformatf("din_rand_%0d_a%0d", i, addr), exp_q);
        end

        // Plain random back-to-back reads.
        d_in = 8'd0;
        for (int i = 0; i < 20; i++) begin
            addr  = 8'($urandom_range(0, 255));
            exp_q = model(int'(addr));
            tick();
            check($sformatf("rand_%0d_a%0d", i, addr), exp_q);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
